// File: rtl/load_store_unit.sv
// Load/store sequencer between the memory stage and the big-endian byte-addressed data memory.
// Checks each request, drives the memory controls and splits SWL/SWR into single-byte writes.
module load_store_unit #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_type,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_type,
    output logic              mem_unsigned,
    output logic [31:0]       mem_rt,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] DATA_TYPE_BYTE  = 3'd0;
    localparam logic [2:0] DATA_TYPE_HALF  = 3'd1;
    localparam logic [2:0] DATA_TYPE_WORD  = 3'd2;
    localparam logic [2:0] DATA_TYPE_WORDL = 3'd3;
    localparam logic [2:0] DATA_TYPE_WORDR = 3'd4;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] SEQ  = 3'd4;
    localparam logic [2:0] RESP = 3'd5;

    // Source byte lane (counted from the LSB) for partial-store write number i.
    function automatic logic [7:0] seq_byte(input logic swl, input logic [1:0] a,
                                            input logic [1:0] i, input logic [31:0] wd);
        logic [1:0] lane;
        logic [7:0] b;
        lane = swl ? (2'd3 - i) : (a - i);
        case (lane)
            2'd0:    b = wd[7:0];
            2'd1:    b = wd[15:8];
            2'd2:    b = wd[23:16];
            2'd3:    b = wd[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte offset within the aligned word for partial-store write number i.
    function automatic logic [1:0] seq_lo(input logic swl, input logic [1:0] a, input logic [1:0] i);
        return swl ? (a + i) : i;
    endfunction

    logic [2:0]        state_r;
    logic              resp_valid_r;
    logic              resp_fault_r;
    logic [31:0]       resp_rdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [2:0]        mem_type_r;
    logic              mem_unsigned_r;
    logic [31:0]       mem_rt_r;

    logic [ADDR_W-3:0] base_r;
    logic [1:0]        off_r;
    logic              swl_r;
    logic [31:0]       wdata_r;
    logic [1:0]        cnt_r;
    logic [1:0]        last_r;

    logic              type_ok_s;
    logic              fault_s;
    logic              req_swl_s;
    logic              req_seq_s;
    logic [1:0]        nxt_cnt_s;

    // Request classification evaluated at the accept edge.
    always_comb begin
        type_ok_s = (req_type == DATA_TYPE_BYTE)  || (req_type == DATA_TYPE_HALF) ||
                    (req_type == DATA_TYPE_WORD)  || (req_type == DATA_TYPE_WORDL) ||
                    (req_type == DATA_TYPE_WORDR);
        fault_s   = !type_ok_s ||
                    (req_addr[31:ADDR_W] != {(32-ADDR_W){1'b0}}) ||
                    ((req_type == DATA_TYPE_WORD) && (req_addr[1:0] != 2'b00)) ||
                    ((req_type == DATA_TYPE_HALF) && req_addr[0]);
        req_swl_s = (req_type == DATA_TYPE_WORDL);
        req_seq_s = req_write && ((req_type == DATA_TYPE_WORDL) || (req_type == DATA_TYPE_WORDR));
        nxt_cnt_s = cnt_r + 2'd1;
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            resp_valid_r   <= 1'b0;
            resp_fault_r   <= 1'b0;
            resp_rdata_r   <= 32'd0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= 32'd0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_type_r     <= 3'd0;
            mem_unsigned_r <= 1'b0;
            mem_rt_r       <= 32'd0;
            base_r         <= {(ADDR_W-2){1'b0}};
            off_r          <= 2'd0;
            swl_r          <= 1'b0;
            wdata_r        <= 32'd0;
            cnt_r          <= 2'd0;
            last_r         <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid_r <= 1'b0;
                    resp_fault_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    mem_read_r   <= 1'b0;
                    mem_write_r  <= 1'b0;
                    if (req_valid) begin
                        if (fault_s) begin
                            resp_valid_r <= 1'b1;
                            resp_fault_r <= 1'b1;
                            state_r      <= RESP;
                        end else if (!req_write) begin
                            mem_read_r     <= 1'b1;
                            mem_addr_r     <= req_addr[ADDR_W-1:0];
                            mem_type_r     <= req_type;
                            mem_unsigned_r <= req_unsigned;
                            mem_rt_r       <= req_rt;
                            state_r        <= RD;
                        end else if (req_seq_s) begin
                            // First byte goes out now; the rest are replayed from latched fields.
                            mem_write_r <= 1'b1;
                            mem_type_r  <= DATA_TYPE_BYTE;
                            mem_addr_r  <= {req_addr[ADDR_W-1:2], seq_lo(req_swl_s, req_addr[1:0], 2'd0)};
                            mem_wdata_r <= {24'h000000, seq_byte(req_swl_s, req_addr[1:0], 2'd0, req_wdata)};
                            base_r      <= req_addr[ADDR_W-1:2];
                            off_r       <= req_addr[1:0];
                            swl_r       <= req_swl_s;
                            wdata_r     <= req_wdata;
                            cnt_r       <= 2'd0;
                            last_r      <= req_swl_s ? (2'd3 - req_addr[1:0]) : req_addr[1:0];
                            state_r     <= SEQ;
                        end else begin
                            mem_write_r <= 1'b1;
                            mem_addr_r  <= req_addr[ADDR_W-1:0];
                            mem_wdata_r <= req_wdata;
                            mem_type_r  <= req_type;
                            state_r     <= WR;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    mem_read_r <= 1'b0;
                    state_r    <= CAP;
                end
                CAP: begin
                    resp_rdata_r <= mem_rdata;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                WR: begin
                    mem_write_r  <= 1'b0;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                SEQ: begin
                    if (cnt_r == last_r) begin
                        mem_write_r  <= 1'b0;
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        cnt_r       <= nxt_cnt_s;
                        mem_addr_r  <= {base_r, seq_lo(swl_r, off_r, nxt_cnt_s)};
                        mem_wdata_r <= {24'h000000, seq_byte(swl_r, off_r, nxt_cnt_s, wdata_r)};
                    end
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_fault_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    state_r      <= IDLE;
                end
                default: begin
                    mem_read_r   <= 1'b0;
                    mem_write_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_fault_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (state_r == IDLE);
    assign resp_valid   = resp_valid_r;
    assign resp_fault   = resp_fault_r;
    assign resp_rdata   = resp_rdata_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign mem_read     = mem_read_r;
    assign mem_write    = mem_write_r;
    assign mem_type     = mem_type_r;
    assign mem_unsigned = mem_unsigned_r;
    assign mem_rt       = mem_rt_r;

endmodule
